// File: rtl/to_ram_pkg.sv
// to_ram_pkg
// Shared definitions for the to_ram_event_source block: FSM state encoding,
// HPS control-register bit positions, status-word field positions, the
// default event-word width, and a helper that packs the status word.
package to_ram_pkg;

  localparam int DATA_W_DFLT = 32;

  // HPS control register (ctrl_fpga_side_reg) bit positions
  localparam int CTRL_RUN_BIT   = 0;
  localparam int CTRL_FLUSH_BIT = 1;

  // Status word (ctrl_hps_side_reg) field positions
  localparam int STAT_USED_LSB     = 0;
  localparam int STAT_USED_W       = 11;
  localparam int STAT_FULL_BIT     = 11;
  localparam int STAT_EMPTY_BIT    = 12;
  localparam int STAT_UNDERRUN_BIT = 13;
  localparam int STAT_FLUSHING_BIT = 14;
  localparam int STAT_RSVD_BIT     = 15;
  localparam int STAT_PKT_LSB      = 16;
  localparam int STAT_PKT_W        = 16;

  // Status after reset: only the empty flag is set
  localparam logic [31:0] STATUS_RST = 32'h0000_1000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  function automatic logic [31:0] pack_status(
    input logic [STAT_USED_W-1:0] used,
    input logic                   full,
    input logic                   empty,
    input logic                   underrun,
    input logic                   flushing,
    input logic [STAT_PKT_W-1:0]  pkt
  );
    logic [31:0] s;
    s = '0;
    s[STAT_USED_LSB +: STAT_USED_W] = used;
    s[STAT_FULL_BIT]                = full;
    s[STAT_EMPTY_BIT]               = empty;
    s[STAT_UNDERRUN_BIT]            = underrun;
    s[STAT_FLUSHING_BIT]            = flushing;
    s[STAT_RSVD_BIT]                = 1'b0;
    s[STAT_PKT_LSB +: STAT_PKT_W]   = pkt;
    return s;
  endfunction

endpackage

// File: rtl/sc_fifo_showahead.sv
// sc_fifo_showahead
// Single-clock show-ahead FIFO built on a RAM with a registered read port.
// The RAM read lands in a one-entry prefetch stage (_p1) which feeds the
// head register (_p2) presented on rd_data. Keeping _p1 filled lets the head
// advance on every acknowledged cycle without a bubble.
// Ports:
//   clk, reset_n  clock and synchronous active-low reset
//   flush         clears pointers, counts and both stages this cycle
//   wr, wr_data   write request / data (ignored while full or flushing)
//   rd_ack        pop the head word (ignored while empty or flushing)
//   rd_data       head word, valid while empty=0
//   empty         no presentable head word
//   full          used == 2^DEPTH_LOG2
//   used          words held, 0..2^DEPTH_LOG2
module sc_fifo_showahead #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                flush,
  input  logic                wr,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                rd_ack,
  output logic [DATA_W-1:0]   rd_data,
  output logic                empty,
  output logic                full,
  output logic [DEPTH_LOG2:0] used
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [DATA_W-1:0]     mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   mem_cnt;   // words still in RAM, not yet fetched

  logic [DATA_W-1:0]     data_p1;
  logic                  vld_p1;
  logic [DATA_W-1:0]     data_p2;
  logic                  vld_p2;

  logic wr_en;
  logic pop;
  logic adv_p1;
  logic free_p1;
  logic fetch;
  logic byp;

  assign wr_en   = wr && !full && !flush;
  assign pop     = rd_ack && vld_p2 && !flush;
  assign adv_p1  = !flush && vld_p1 && (!vld_p2 || pop);
  assign free_p1 = !vld_p1 || adv_p1;
  assign fetch   = !flush && (mem_cnt != '0) && free_p1;
  // When the RAM is drained but a word is already in flight, the new word is
  // captured straight into _p1 so a following pop does not bubble. A write
  // into a completely empty FIFO takes the RAM path instead.
  assign byp     = wr_en && (mem_cnt == '0) && free_p1 && (vld_p1 || vld_p2);

  assign rd_data = data_p2;
  assign empty   = !vld_p2 || flush;
  assign full    = (used == FULL_CNT);

  // RAM write port
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_data;
  end

  // Stage p1: registered RAM read or write-data bypass
  always_ff @(posedge clk) begin
    if (fetch)    data_p1 <= mem[rd_ptr];
    else if (byp) data_p1 <= wr_data;
  end

  // Stage p2: head register presented to the reader
  always_ff @(posedge clk) begin
    if (!reset_n)    data_p2 <= '0;
    else if (adv_p1) data_p2 <= data_p1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      mem_cnt <= '0;
      used    <= '0;
      vld_p1  <= 1'b0;
      vld_p2  <= 1'b0;
    end else begin
      if (wr_en)         wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (fetch || byp)  rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
      mem_cnt <= mem_cnt + CW'(wr_en && !byp) - CW'(fetch);
      used    <= used + CW'(wr_en) - CW'(pop);
      if (fetch || byp || adv_p1) vld_p1 <= fetch || byp;
      if (adv_p1 || pop)          vld_p2 <= adv_p1;
    end
  end

endmodule

// File: rtl/to_ram_event_source.sv
// to_ram_event_source
// FPGA-side producer for the HPS to_ram_fifo / to_ram_ctrl conduits. DAQ
// event words are buffered in a show-ahead FIFO whose head is offered on
// fifo_data_event; each fifo_data_ack pulse pops one word. The HPS control
// register selects IDLE/RUN and requests FLUSH; a registered status word
// reports fill level, flags and the accepted-packet count.
// Ports:
//   clk, reset_n                 clock, synchronous active-low reset
//   in_valid, in_data, in_last   DAQ word stream input
//   in_ready                     word accepted this cycle when in_valid=1
//   fifo_data_event/_empty       head word and its empty flag
//   fifo_data_ack                one-cycle pop request
//   ctrl_fpga_side_reg           bit0 RUN, bit1 FLUSH
//   ctrl_hps_side_reg            packed status word
//   ctrl_enable                  high while in RUN
module to_ram_event_source
  import to_ram_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DFLT,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [DATA_W-1:0] fifo_data_event,
  output logic              fifo_data_empty,
  input  logic              fifo_data_ack,
  input  logic [31:0]       ctrl_fpga_side_reg,
  output logic [31:0]       ctrl_hps_side_reg,
  output logic              ctrl_enable
);

  state_t                state;
  logic                  run_bit;
  logic                  flush_bit;
  logic                  flush_q;
  logic                  flush_edge;
  logic                  flushing;
  logic                  wr_acc;
  logic                  fifo_full;
  logic [DEPTH_LOG2:0]   fifo_used;
  logic [STAT_PKT_W-1:0] pkt_cnt;
  logic                  underrun;
  logic                  ctrl_unused;

  assign run_bit     = ctrl_fpga_side_reg[CTRL_RUN_BIT];
  assign flush_bit   = ctrl_fpga_side_reg[CTRL_FLUSH_BIT];
  assign ctrl_unused = ^ctrl_fpga_side_reg[31:2];
  assign flush_edge  = flush_bit && !flush_q;
  assign flushing    = (state == ST_FLUSH);
  assign in_ready    = (state == ST_RUN) && !fifo_full;
  assign wr_acc      = in_valid && in_ready;

  sc_fifo_showahead #(
    .DATA_W     (DATA_W),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flushing),
    .wr      (wr_acc),
    .wr_data (in_data),
    .rd_ack  (fifo_data_ack),
    .rd_data (fifo_data_event),
    .empty   (fifo_data_empty),
    .full    (fifo_full),
    .used    (fifo_used)
  );

  // Control FSM; a FLUSH edge wins over any RUN change in the same cycle
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      ctrl_enable <= 1'b0;
      flush_q     <= 1'b0;
    end else begin
      flush_q <= flush_bit;
      case (state)
        ST_IDLE: begin
          if (flush_edge) begin
            state       <= ST_FLUSH;
            ctrl_enable <= 1'b0;
          end else if (run_bit) begin
            state       <= ST_RUN;
            ctrl_enable <= 1'b1;
          end
        end
        ST_RUN: begin
          if (flush_edge) begin
            state       <= ST_FLUSH;
            ctrl_enable <= 1'b0;
          end else if (!run_bit) begin
            state       <= ST_IDLE;
            ctrl_enable <= 1'b0;
          end
        end
        ST_FLUSH: begin
          state       <= ST_IDLE;
          ctrl_enable <= 1'b0;
        end
        default: begin
          state       <= ST_IDLE;
          ctrl_enable <= 1'b0;
        end
      endcase
    end
  end

  // Packet counter, underrun sticky and status register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pkt_cnt           <= '0;
      underrun          <= 1'b0;
      ctrl_hps_side_reg <= STATUS_RST;
    end else begin
      if (flushing) begin
        pkt_cnt  <= '0;
        underrun <= 1'b0;
      end else begin
        if (wr_acc && in_last)                 pkt_cnt  <= pkt_cnt + STAT_PKT_W'(1);
        if (fifo_data_ack && fifo_data_empty)  underrun <= 1'b1;
      end
      ctrl_hps_side_reg <= pack_status(STAT_USED_W'(fifo_used), fifo_full,
                                       (fifo_used == '0), underrun, flushing,
                                       pkt_cnt);
    end
  end

endmodule

// File: tb/tb_to_ram_event_source.sv
module tb_to_ram_event_source;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_last;
  logic        in_ready;
  logic [31:0] fifo_data_event;
  logic        fifo_data_empty;
  logic        fifo_data_ack;
  logic [31:0] ctrl_fpga_side_reg;
  logic [31:0] ctrl_hps_side_reg;
  logic        ctrl_enable;

  int n_asserts = 0;
  int n_fail    = 0;
  logic [31:0] sb[$];

  always #5 clk = ~clk;

  to_ram_event_source dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .in_valid           (in_valid),
    .in_data            (in_data),
    .in_last            (in_last),
    .in_ready           (in_ready),
    .fifo_data_event    (fifo_data_event),
    .fifo_data_empty    (fifo_data_empty),
    .fifo_data_ack      (fifo_data_ack),
    .ctrl_fpga_side_reg (ctrl_fpga_side_reg),
    .ctrl_hps_side_reg  (ctrl_hps_side_reg),
    .ctrl_enable        (ctrl_enable)
  );

  function automatic logic [31:0] st(input int used, input bit full, input bit empty,
                                     input bit und, input bit fl, input int pkt);
    return {pkt[15:0], 1'b0, fl, und, empty, full, used[10:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Samples at the falling edge: records accepted words and checks pops,
  // then advances to 1 time unit after the next rising edge.
  task automatic tick();
    logic [31:0] exp;
    @(negedge clk);
    if (in_valid && in_ready) sb.push_back(in_data);
    if (fifo_data_ack && !fifo_data_empty) begin
      if (sb.size() != 0) exp = sb.pop_front();
      else                exp = 'x;
      chk("pop_data", fifo_data_event, exp);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int acc;
    int cyc;
    reset_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    fifo_data_ack = 1'b0; ctrl_fpga_side_reg = '0;

    // Reset state
    repeat (3) tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_empty", fifo_data_empty, 1);
    chk("rst_event", fifo_data_event, 0);
    chk("rst_enable", ctrl_enable, 0);
    chk("rst_status", ctrl_hps_side_reg, 32'h0000_1000);

    // RUN, four-word packet, two-cycle show-ahead latency
    reset_n = 1'b1;
    ctrl_fpga_side_reg = 32'h1;
    tick();
    chk("run_enable", ctrl_enable, 1);
    chk("run_in_ready", in_ready, 1);
    in_valid = 1'b1; in_data = 32'hA000_0001; tick();
    chk("lat_empty_1", fifo_data_empty, 1);
    in_data = 32'hA000_0002; tick();
    chk("lat_empty_2", fifo_data_empty, 1);
    in_data = 32'hA000_0003; tick();
    chk("lat_empty_3", fifo_data_empty, 0);
    chk("lat_head", fifo_data_event, 32'hA000_0001);
    in_data = 32'hA000_0004; in_last = 1'b1; tick();
    in_valid = 1'b0; in_last = 1'b0;
    repeat (2) tick();
    fifo_data_ack = 1'b1;
    repeat (4) tick();
    fifo_data_ack = 1'b0;
    chk("pkt1_drained", fifo_data_empty, 1);
    tick();
    chk("pkt1_status", ctrl_hps_side_reg, st(0, 0, 1, 0, 0, 1));

    // Fill to 1024 words
    in_valid = 1'b1;
    for (int i = 0; i < 1024; i++) begin
      in_data = 32'hB000_0000 + 32'(i);
      tick();
    end
    chk("full_in_ready", in_ready, 0);
    in_data = 32'hB000_0400;
    tick();
    chk("full_status", ctrl_hps_side_reg, st(1024, 1, 0, 0, 0, 1));
    fifo_data_ack = 1'b1; tick(); fifo_data_ack = 1'b0;
    chk("full_ack_ready", in_ready, 1);
    tick();
    chk("full_one_more", in_ready, 0);
    in_valid = 1'b0;
    fifo_data_ack = 1'b1;
    repeat (1024) tick();
    fifo_data_ack = 1'b0;
    chk("full_drained", fifo_data_empty, 1);
    tick();
    chk("full_drain_status", ctrl_hps_side_reg, st(0, 0, 1, 0, 0, 1));

    // Underrun sticky, cleared by a FLUSH edge
    fifo_data_ack = 1'b1; tick(); fifo_data_ack = 1'b0;
    chk("und_empty", fifo_data_empty, 1);
    tick();
    chk("und_status", ctrl_hps_side_reg, st(0, 0, 1, 1, 0, 1));
    repeat (2) tick();
    chk("und_hold", ctrl_hps_side_reg, st(0, 0, 1, 1, 0, 1));
    ctrl_fpga_side_reg = 32'h3;
    tick();
    chk("und_fl_enable", ctrl_enable, 0);
    chk("und_fl_ready", in_ready, 0);
    tick();
    chk("und_fl_status", ctrl_hps_side_reg, st(0, 0, 1, 1, 1, 1));
    tick();
    chk("und_cleared", ctrl_hps_side_reg, st(0, 0, 1, 0, 0, 0));
    chk("und_rerun", ctrl_enable, 1);
    ctrl_fpga_side_reg = 32'h1;

    // Five queued words popped on five consecutive cycles
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = 32'hC000_0000 + 32'(i);
      in_last = (i == 4);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    repeat (3) tick();
    fifo_data_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("burst_head_vld", fifo_data_empty, 0);
      tick();
    end
    fifo_data_ack = 1'b0;
    chk("burst_empty", fifo_data_empty, 1);

    // FLUSH with an ack held across it
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 32'hD000_0000 + 32'(i);
      in_last = (i == 2);
      tick();
    end
    in_valid = 1'b0; in_last = 1'b0;
    repeat (3) tick();
    ctrl_fpga_side_reg = 32'h3; fifo_data_ack = 1'b1;
    tick();
    chk("fl_empty", fifo_data_empty, 1);
    chk("fl_enable", ctrl_enable, 0);
    tick();
    fifo_data_ack = 1'b0;
    chk("fl_status", ctrl_hps_side_reg, st(2, 0, 0, 0, 1, 2));
    chk("fl_idle_enable", ctrl_enable, 0);
    sb.delete();
    tick();
    chk("fl_after_status", ctrl_hps_side_reg, st(0, 0, 1, 0, 0, 0));
    chk("fl_rerun", ctrl_enable, 1);
    chk("fl_after_empty", fifo_data_empty, 1);
    ctrl_fpga_side_reg = 32'h1;

    // Drop RUN mid-packet
    in_valid = 1'b1; in_data = 32'hE000_0000; tick();
    in_data = 32'hE000_0001; ctrl_fpga_side_reg = 32'h0; tick();
    chk("drop_ready", in_ready, 0);
    chk("drop_enable", ctrl_enable, 0);
    in_data = 32'hE000_0002;
    repeat (2) tick();
    in_valid = 1'b0;
    fifo_data_ack = 1'b1;
    repeat (2) tick();
    fifo_data_ack = 1'b0;
    chk("drop_drained", fifo_data_empty, 1);

    // Reset mid-operation discards contents
    ctrl_fpga_side_reg = 32'h1; tick();
    in_valid = 1'b1; in_data = 32'hF000_0000; tick();
    in_data = 32'hF000_0001; tick();
    in_valid = 1'b0; tick();
    reset_n = 1'b0; tick();
    sb.delete();
    chk("mrst_empty", fifo_data_empty, 1);
    chk("mrst_ready", in_ready, 0);
    chk("mrst_enable", ctrl_enable, 0);
    chk("mrst_status", ctrl_hps_side_reg, 32'h0000_1000);
    reset_n = 1'b1; tick();
    chk("mrst_status2", ctrl_hps_side_reg, 32'h0000_1000);

    // Packet counter wrap: 65535 single-word packets, then one more
    acc = 0; cyc = 0;
    in_valid = 1'b1; in_last = 1'b1;
    while (acc < 65535 && cyc < 70000) begin
      in_data = 32'h5000_0000 + 32'(acc);
      fifo_data_ack = !fifo_data_empty;
      if (in_ready) acc++;
      tick();
      cyc++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    chk("wrap_accepts", 32'(acc), 32'd65535);
    for (int k = 0; k < 16; k++) begin
      fifo_data_ack = !fifo_data_empty;
      tick();
    end
    fifo_data_ack = 1'b0;
    chk("wrap_drained", fifo_data_empty, 1);
    tick();
    chk("wrap_ffff", ctrl_hps_side_reg, st(0, 0, 1, 0, 0, 16'hFFFF));
    in_valid = 1'b1; in_last = 1'b1; in_data = 32'h6000_0000; tick();
    in_valid = 1'b0; in_last = 1'b0;
    repeat (2) tick();
    chk("wrap_zero", 32'(ctrl_hps_side_reg[31:16]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/to_ram_event_source.md
# to_ram_event_source

FPGA-fabric producer for the HPS-side `to_ram_fifo` / `to_ram_ctrl` conduits of `soc_system`. It buffers 32-bit DAQ event words in a show-ahead FIFO and presents the head word on `fifo_data_event`/`fifo_data_empty`. It pops one word per `fifo_data_ack` pulse from the HPS DMA reader. It also decodes the HPS control register, drives `ctrl_enable`, and returns a status word to the HPS.

## Interface
- `DATA_W`, 32, event word width; must equal the conduit width.
- `DEPTH_LOG2`, 10, FIFO depth is 2^DEPTH_LOG2 words (1024).
- `clk`  in  1  single system clock; all logic on its rising edge.
- `reset_n`  in  1  reset; synchronous, active-low.
- `in_valid`  in  1  DAQ word valid.
- `in_data`  in  DATA_W  DAQ event word.
- `in_last`  in  1  marks the final word of an event packet.
- `in_ready`  out  1  block accepts a word this cycle.
- `fifo_data_event`  out  DATA_W  head-of-FIFO word; valid while `fifo_data_empty`=0.
- `fifo_data_empty`  out  1  FIFO has no presentable word.
- `fifo_data_ack`  in  1  one-cycle pop request from the HPS side.
- `ctrl_fpga_side_reg`  in  32  HPS-written control: bit0 RUN, bit1 FLUSH; other bits reserved and ignored.
- `ctrl_hps_side_reg`  out  32  status to the HPS:
  - [10:0] used words
  - [11] full
  - [12] empty
  - [13] underrun sticky
  - [14] flushing
  - [15] reserved, 0
  - [31:16] accepted-packet count, mod 2^16
- `ctrl_enable`  out  1  high in RUN state.

## Operation
- FSM states: IDLE, RUN, FLUSH.
  - IDLE → RUN when RUN=1.
  - RUN → IDLE when RUN=0.
  - IDLE or RUN → FLUSH on a 0→1 edge of FLUSH. The edge is detected against a registered copy of bit1. FLUSH takes priority over a RUN change in the same cycle.
  - FLUSH → IDLE after exactly one cycle. The next cycle re-evaluates RUN.
- `in_ready` = (state==RUN) && !full. A word is written when `in_valid` && `in_ready`; all other input words are not accepted. Upstream holds them.
- Packet counter increments on each accepted word with `in_last`=1. It wraps from 0xFFFF to 0.
- Pop: `fifo_data_ack` with `fifo_data_empty`=0 removes the head. Pops are served in every state except FLUSH.
- `fifo_data_ack` with `fifo_data_empty`=1 is ignored and sets the underrun sticky.
- A FLUSH cycle does all of the following:
  - resets the read and write pointers and the used count;
  - clears the underrun sticky and the packet counter;
  - forces `fifo_data_empty`=1.
  An ack during FLUSH is ignored and does not set the sticky.
- Dropping RUN mid-packet does not discard the words already accepted. The partial packet stays readable.
- Used count range is 0..2^DEPTH_LOG2. Full means used == 2^DEPTH_LOG2. At depth 1024, status [10:0] reads 1024 when full.
- Pointers are DEPTH_LOG2 bits and wrap naturally; full/empty come from the count, not from pointer compare.

## Timing
- Reset values:
  - `in_ready`=0, `fifo_data_empty`=1, `fifo_data_event`=0, `ctrl_enable`=0;
  - status = 0x0000_1000 (empty bit only);
  - state IDLE; pointers, count, counter and sticky all 0.
- Reset asserted mid-operation discards all contents on that edge.
- Write into an empty FIFO: the word is on `fifo_data_event` with `fifo_data_empty`=0 two cycles after the write edge, because the RAM read is registered.
- Back-to-back pops: if at least 2 words remain at an ack, the next head is valid on the following cycle with no bubble. A one-entry prefetch register is required to achieve this.
- Simultaneous write and pop: the count is unchanged. With count=1, the presented word may bubble for at most one cycle (`fifo_data_empty`=1), then shows the new word.
- Status register and `ctrl_enable` are registered and lag their causes by one cycle.
- `in_ready` is combinational from state and full.

## Structure
- Package `to_ram_pkg`:
  - state enum;
  - CTRL_RUN_BIT=0, CTRL_FLUSH_BIT=1;
  - status field bit positions;
  - DATA_W default.
- Sub-module `sc_fifo_showahead`:
  - single-clock RAM FIFO with prefetch register;
  - ports: write, read-ack, flush, used, full, empty;
  - parameterised by DATA_W and DEPTH_LOG2.
- The top level holds the FSM, the edge detect, the packet counter, the underrun sticky and the status packing.

## Test plan
- Reset, then set RUN=1 and write 0xA0000001..0xA0000004 with `in_last` on the 4th → empty falls 2 cycles after the first write; acks return the same 4 words in order; status[31:16]=1.
- Fill 1024 words with no acks → `in_ready`=0 and status = full, used=1024; one ack lets exactly one more write in.
- Ack while empty → underrun bit [13]=1 and stays set; data unchanged; a FLUSH edge clears it.
- Ack every cycle while 5 words are queued → 5 consecutive distinct words on 5 consecutive cycles, then empty=1.
- Write 3 words, pulse FLUSH with simultaneous ack → empty=1, used=0, packet count 0; state goes through FLUSH to IDLE and re-enters RUN if RUN=1.
- Drop RUN mid-packet after 2 of 4 words → `in_ready`=0 next cycle, `ctrl_enable`=0; both words remain readable.
